botao_pedestre: RTL and testbench

BOTAO_PEDESTRE -- requirements
Module: botao_pedestre

---
 rtl/botao_pedestre_pkg.sv | 23 ++
 rtl/botao_pedestre_debounce_sync.sv | 41 ++++
 rtl/botao_pedestre.sv | 113 +++++++++++
 tb/tb_botao_pedestre.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/botao_pedestre_pkg.sv
// Shared light and FSM encodings for the traffic-light controller and the
// pedestrian request block.
package botao_pedestre_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_t;

  localparam logic [2:0] A_GREEN    = 3'b001;
  localparam logic [2:0] A_YELLOW   = 3'b010;
  localparam logic [2:0] A_RED      = 3'b100;
  localparam logic [2:0] B_STOP     = 3'b001;
  localparam logic [2:0] B_WALK     = 3'b010;
  localparam logic [2:0] B_WALK_END = 3'b100;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/botao_pedestre_debounce_sync.sv
// Two-flop synchronizer followed by a stability-count debouncer; any bounce
// back to the current level restarts the count.
module debounce_sync #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;

  // synchronize the raw input and accept a new level after DEB_CYCLES stable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      dout    <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r != dout) begin
        if (cnt_r == CNT_W'(DEB_CYCLES - 1)) begin
          dout  <= sync2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/botao_pedestre.sv
// Pedestrian push-button request block: debounces the button, raises a
// crossing request and tracks service by the traffic-light controller.
module botao_pedestre
  import botao_pedestre_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       bt,
  output logic       wait_led,
  output logic [7:0] req_count,
  output logic       err
);

  localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic             deb_s;
  logic             deb_q_r;
  logic             press_s;
  logic             a_green_s;
  logic             b_stop_s;
  logic             b_served_s;
  logic             bad_s;
  ped_state_t       state_r;
  logic [LCK_W-1:0] lock_cnt_r;

  debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_debounce_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_raw),
    .dout (deb_s)
  );

  // press edge and light decoding; illegal codes are neither green nor served
  always_comb begin
    press_s    = deb_s & ~deb_q_r;
    a_green_s  = (A == A_GREEN);
    b_stop_s   = (B == B_STOP);
    b_served_s = (B == B_WALK) || (B == B_WALK_END);
    bad_s      = !is_onehot3(A) || !is_onehot3(B);
  end

  // request FSM with registered outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      deb_q_r    <= 1'b0;
      lock_cnt_r <= '0;
      bt         <= 1'b0;
      wait_led   <= 1'b0;
      req_count  <= 8'd0;
      err        <= 1'b0;
    end else begin
      deb_q_r <= deb_s;
      err     <= err | bad_s;
      case (state_r)
        IDLE: begin
          if (press_s) begin
            state_r   <= PENDING;
            bt        <= 1'b1;
            wait_led  <= 1'b1;
            req_count <= req_count + 8'd1;
          end else begin
            bt       <= 1'b0;
            wait_led <= 1'b0;
          end
        end
        PENDING: begin
          if (b_served_s) begin
            state_r  <= SERVING;
            bt       <= 1'b1;
            wait_led <= 1'b0;
          end else begin
            bt       <= 1'b1;
            wait_led <= 1'b1;
          end
        end
        SERVING: begin
          if (b_stop_s && a_green_s) begin
            state_r    <= LOCKOUT;
            lock_cnt_r <= LCK_W'(LOCKOUT_CYCLES - 1);
            bt         <= 1'b0;
            wait_led   <= 1'b0;
          end else begin
            bt       <= 1'b1;
            wait_led <= 1'b0;
          end
        end
        LOCKOUT: begin
          // presses here, including the expiry cycle, are dropped
          bt       <= 1'b0;
          wait_led <= 1'b0;
          if (lock_cnt_r == '0) begin
            state_r <= IDLE;
          end else begin
            lock_cnt_r <= lock_cnt_r - LCK_W'(1);
          end
        end
        default: begin
          state_r  <= IDLE;
          bt       <= 1'b0;
          wait_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_botao_pedestre.sv
// Directed bench for botao_pedestre: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived from the request timing.
module tb_botao_pedestre;
  import botao_pedestre_pkg::*;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic [2:0] A;
  logic [2:0] B;
  logic       bt;
  logic       wait_led;
  logic [7:0] req_count;
  logic       err;

  int vectors;
  int miscompares;

  botao_pedestre #(.DEB_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .A         (A),
    .B         (B),
    .bt        (bt),
    .wait_led  (wait_led),
    .req_count (req_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_bt, input logic e_wait,
                         input logic [7:0] e_cnt, input logic e_err);
    chk1({tag, ".bt"}, bt, e_bt);
    chk1({tag, ".wait_led"}, wait_led, e_wait);
    chk8({tag, ".req_count"}, req_count, e_cnt);
    chk1({tag, ".err"}, err, e_err);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    btn_raw = 1'b0;
    A       = A_GREEN;
    B       = B_STOP;
    step(2);
    chk_out("reset", 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    step(2);

    // bounce: two-cycle pulses never survive the 4-cycle filter
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b1;
      step(2);
      btn_raw = 1'b0;
      step(2);
      chk1("bounce_mid.bt", bt, 1'b0);
    end
    step(8);
    chk_out("bounce_end", 1'b0, 1'b0, 8'd0, 1'b0);

    // clean press: bt rises at cycle 7
    btn_raw = 1'b1;
    step(6);
    chk1("press_c6.bt", bt, 1'b0);
    step(1);
    chk_out("press_c7", 1'b1, 1'b1, 8'd1, 1'b0);
    chk8("press_c7.state", 8'(dut.state_r), 8'(PENDING));
    step(3);
    btn_raw = 1'b0;
    step(8);

    // repeated presses while pending are absorbed
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b1;
      step(8);
      btn_raw = 1'b0;
      step(8);
    end
    chk_out("repeat", 1'b1, 1'b1, 8'd1, 1'b0);

    // illegal A for one cycle sets sticky err, FSM stays pending
    A = 3'b011;
    step(1);
    chk1("illegal_next.err", err, 1'b1);
    A = A_GREEN;
    step(3);
    chk_out("illegal_hold", 1'b1, 1'b1, 8'd1, 1'b1);

    // service: walk, walk-ending, then stop with non-green A holds SERVING
    B = B_WALK;
    step(1);
    chk_out("serving_walk", 1'b1, 1'b0, 8'd1, 1'b1);
    B = B_WALK_END;
    step(2);
    chk8("serving_end.state", 8'(dut.state_r), 8'(SERVING));
    B = B_STOP;
    A = A_RED;
    step(2);
    chk1("serving_red.bt", bt, 1'b1);
    A = A_GREEN;
    step(1);
    chk_out("lockout_enter", 1'b0, 1'b0, 8'd1, 1'b1);
    chk8("lockout_enter.state", 8'(dut.state_r), 8'(LOCKOUT));

    // press pulse lands in the expiry cycle of lockout and is dropped
    step(1);
    btn_raw = 1'b1;
    step(6);
    chk8("lockout_last.state", 8'(dut.state_r), 8'(LOCKOUT));
    step(1);
    chk8("lockout_exit.state", 8'(dut.state_r), 8'(IDLE));
    chk_out("lockout_exit", 1'b0, 1'b0, 8'd1, 1'b1);
    step(4);
    btn_raw = 1'b0;
    step(8);
    chk1("after_lockout.bt", bt, 1'b0);

    // fresh press after lockout counts again
    btn_raw = 1'b1;
    step(6);
    chk1("press2_c6.bt", bt, 1'b0);
    step(1);
    chk_out("press2_c7", 1'b1, 1'b1, 8'd2, 1'b1);
    step(3);
    btn_raw = 1'b0;
    step(8);

    // reset while serving clears everything immediately
    B = B_WALK;
    step(1);
    chk_out("pre_reset", 1'b1, 1'b0, 8'd2, 1'b1);
    btn_raw = 1'b1;
    rst     = 1'b1;
    #1;
    chk_out("mid_reset", 1'b0, 1'b0, 8'd0, 1'b0);
    chk8("mid_reset.state", 8'(dut.state_r), 8'(IDLE));
    B = B_STOP;
    step(2);
    rst = 1'b0;

    // button held through reset release needs the full filter delay
    step(6);
    chk_out("held_c6", 1'b0, 1'b0, 8'd0, 1'b0);
    step(1);
    chk_out("held_c7", 1'b1, 1'b1, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
